// File: rtl/writeback_if.sv
// Writeback port bundle: ALU and load result offers, register-file write port,
// decode-stage hazard lookup and queue occupancy.
interface writeback_if #(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_addr;
  logic [31:0]              alu_data;
  logic                     alu_ready;
  logic                     mem_valid;
  logic [4:0]               mem_addr;
  logic [31:0]              mem_data;
  logic                     mem_ready;
  logic                     write_reg;
  logic [4:0]               write_reg_addr;
  logic [31:0]              write_reg_data;
  logic [4:0]               read_reg1;
  logic [4:0]               read_reg2;
  logic                     pending1;
  logic                     pending2;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  read_reg1, read_reg2,
    output alu_ready, mem_ready,
    output write_reg, write_reg_addr, write_reg_data,
    output pending1, pending2, count
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output read_reg1, read_reg2,
    input  alu_ready, mem_ready,
    input  write_reg, write_reg_addr, write_reg_data,
    input  pending1, pending2, count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback queue: merges ALU and load results into one register-file write
// port, draining one entry per cycle, with pending-write lookup for decode.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  wb
);
  localparam int PW = $clog2(DEPTH);

  // Handshake: a source transfers on a rising edge where its valid and ready
  // are both high; ready never depends on the same source's valid, and a
  // transfer to register 0 completes without being queued.
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count_q;
  logic [36:0]   entries [DEPTH];

  logic        full, empty;
  logic        mem_take, alu_take, push, pop;
  logic [4:0]  push_addr;
  logic [31:0] push_data;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign wb.mem_ready = !rst && !full;
  assign wb.alu_ready = !rst && !full && !wb.mem_valid;

  assign mem_take  = wb.mem_valid && wb.mem_ready;
  assign alu_take  = wb.alu_valid && wb.alu_ready;
  assign push_addr = mem_take ? wb.mem_addr : wb.alu_addr;
  assign push_data = mem_take ? wb.mem_data : wb.alu_data;
  assign push      = (mem_take || alu_take) && (push_addr != 5'd0);
  assign pop       = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is left uninitialised; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= {push_addr, push_data};
  end

  assign wb.write_reg      = !empty;
  assign wb.write_reg_addr = empty ? 5'd0  : entries[rd_ptr][36:32];
  assign wb.write_reg_data = empty ? 32'd0 : entries[rd_ptr][31:0];
  assign wb.count          = count_q;

  function automatic logic entry_live(input logic [PW-1:0] idx,
                                      input logic [PW-1:0] head,
                                      input logic [PW:0]   occ);
    logic [PW-1:0] off;
    off = idx - head;
    return {1'b0, off} < occ;
  endfunction

  always_comb begin
    wb.pending1 = 1'b0;
    wb.pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live(PW'(i), rd_ptr, count_q)) begin
        if (wb.read_reg1 != 5'd0 && entries[i][36:32] == wb.read_reg1) wb.pending1 = 1'b1;
        if (wb.read_reg2 != 5'd0 && entries[i][36:32] == wb.read_reg2) wb.pending2 = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [36:0] exp_q[$];

  writeback_if #(.DEPTH(DEPTH)) wb ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, check every output against
  // the model, then advance the model across the coming rising edge.
  task automatic step(input logic rs,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic        e_mr, e_ar, e_p1, e_p2;
    logic [36:0] head;
    @(negedge clk);
    rst          = rs;
    wb.mem_valid = mv; wb.mem_addr = ma; wb.mem_data = md;
    wb.alu_valid = av; wb.alu_addr = aa; wb.alu_data = ad;
    wb.read_reg1 = r1; wb.read_reg2 = r2;
    #1;
    if (rs) exp_q.delete();
    e_mr = !rs && (exp_q.size() < DEPTH);
    e_ar = e_mr && !mv;
    head = (exp_q.size() > 0) ? exp_q[0] : 37'd0;
    e_p1 = 1'b0;
    e_p2 = 1'b0;
    foreach (exp_q[i]) begin
      if (r1 != 0 && exp_q[i][36:32] == r1) e_p1 = 1'b1;
      if (r2 != 0 && exp_q[i][36:32] == r2) e_p2 = 1'b1;
    end
    check("mem_ready", 64'(wb.mem_ready), 64'(e_mr));
    check("alu_ready", 64'(wb.alu_ready), 64'(e_ar));
    check("write_reg", 64'(wb.write_reg), 64'(exp_q.size() > 0));
    check("wr_addr",   64'(wb.write_reg_addr), 64'(head[36:32]));
    check("wr_data",   64'(wb.write_reg_data), 64'(head[31:0]));
    check("pending1",  64'(wb.pending1), 64'(e_p1));
    check("pending2",  64'(wb.pending2), 64'(e_p2));
    check("count",     64'(wb.count), 64'(exp_q.size()));
    if (!rs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (mv && e_mr) begin
        if (ma != 0) exp_q.push_back({ma, md});
      end else if (av && e_ar) begin
        if (aa != 0) exp_q.push_back({aa, ad});
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    wb.mem_valid = 1'b0; wb.mem_addr = '0; wb.mem_data = '0;
    wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
    wb.read_reg1 = '0;   wb.read_reg2 = '0;

    // reset holds everything idle even with offers present
    step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
    idle(5'd0, 5'd0);

    // single ALU write, one-cycle pulse
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // mem wins over alu, alu follows
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // write to register 0 is accepted and dropped
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // pending lookup on a queued entry
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);

    // both sources held high continuously
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 5'(1 + i % 31), 32'(i), 1'b1, 5'd9, 32'hA5A5, 5'd9, 5'(1 + i % 31));
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // asynchronous reset with an entry in flight
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    @(negedge clk);
    wb.alu_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_count", 64'(wb.count), 64'd0);
    check("async_wr",    64'(wb.write_reg), 64'd0);
    check("async_pend",  64'(wb.pending1), 64'd0);
    check("async_ardy",  64'(wb.alu_ready), 64'd0);
    check("async_mrdy",  64'(wb.mem_ready), 64'd0);
    exp_q.delete();
    step(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
    idle(5'd6, 5'd0);
    idle(5'd6, 5'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
